// File: rtl/dtw_src_unpacker.sv
// AXI-Stream sample unpacker feeding a FWFT FIFO for the DTW reference loader.
// Define DTW_SRC_BYTESWAP_EN to byte-reverse each lane before it is pushed.
module dtw_src_unpacker #(
   parameter int AXIS_WIDTH       = 64,
   parameter int DATA_WIDTH       = 16,
   parameter int FIFO_DEPTH_LOG2  = 6,
   parameter int REFMEM_PTR_WIDTH = 20
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        fifo_clear_in,
   input  logic [AXIS_WIDTH-1:0]       s_axis_tdata,
   input  logic [AXIS_WIDTH/8-1:0]     s_axis_tkeep,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   output logic                        s_axis_tready,
   input  logic                        fifo_rden_in,
   output logic                        fifo_empty_out,
   output logic [DATA_WIDTH-1:0]       fifo_data_out,
   output logic [FIFO_DEPTH_LOG2:0]    fifo_count_out,
   output logic [REFMEM_PTR_WIDTH-1:0] sample_count_out,
   output logic                        last_seen_out,
   output logic                        dbg_state
);

   localparam int LANES = AXIS_WIDTH / DATA_WIDTH;
   localparam int BPL   = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      UNPACK = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [AXIS_WIDTH-1:0]       hold_data_q;
   logic [LANES-1:0]            hold_mask_q;
   logic                        hold_last_q;
   logic [DATA_WIDTH-1:0]       mem_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0]  wptr_q, rptr_q;
   logic [FIFO_DEPTH_LOG2:0]    count_q;
   logic [REFMEM_PTR_WIDTH-1:0] sample_cnt_q;
   logic                        last_seen_q;

   logic [LANES-1:0]      in_mask;
   logic [LANES-1:0]      mask_rest;
   logic [LW-1:0]         lane_idx;
   logic [DATA_WIDTH-1:0] lane_data;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  full, empty;
   logic                  ready_ok;
   logic                  tready_c;
   logic                  push, pop, load, set_last;

   assign full     = (count_q == (FIFO_DEPTH_LOG2+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = fifo_rden_in && !empty;
   assign ready_ok = rst_n_in && !fifo_clear_in;

   // A lane survives only if every one of its bytes is kept
   always_comb begin
      in_mask = '0;
      for (int k = 0; k < LANES; k++)
         in_mask[k] = &s_axis_tkeep[k*BPL +: BPL];
   end

   always_comb begin
      lane_idx = '0;
      for (int k = LANES-1; k >= 0; k--)
         if (hold_mask_q[k])
            lane_idx = LW'(k);
   end

   assign mask_rest = hold_mask_q & (hold_mask_q - 1'b1);
   assign lane_data = hold_data_q[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef DTW_SRC_BYTESWAP_EN
   always_comb begin
      push_data = '0;
      for (int b = 0; b < BPL; b++)
         push_data[b*8 +: 8] = lane_data[(BPL-1-b)*8 +: 8];
   end
`else
   assign push_data = lane_data;
`endif

   always_comb begin
      state_d  = state_q;
      tready_c = 1'b0;
      push     = 1'b0;
      load     = 1'b0;
      set_last = 1'b0;
      unique case (state_q)
         IDLE: begin
            tready_c = ready_ok;
            if (s_axis_tvalid && tready_c) begin
               load = 1'b1;
               if (|in_mask)
                  state_d = UNPACK;
               else if (s_axis_tlast)
                  set_last = 1'b1;
            end
         end
         UNPACK: begin
            if (!full) begin
               push = 1'b1;
               // Final lane: open the stream so beats chain without a bubble
               if (mask_rest == '0) begin
                  tready_c = ready_ok;
                  if (hold_last_q)
                     set_last = 1'b1;
                  if (s_axis_tvalid && tready_c) begin
                     load = 1'b1;
                     if (!(|in_mask)) begin
                        state_d = IDLE;
                        if (s_axis_tlast)
                           set_last = 1'b1;
                     end
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         hold_data_q <= '0;
         hold_mask_q <= '0;
         hold_last_q <= 1'b0;
      end else if (fifo_clear_in) begin
         state_q     <= IDLE;
         hold_data_q <= '0;
         hold_mask_q <= '0;
         hold_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            hold_data_q <= s_axis_tdata;
            hold_mask_q <= in_mask;
            hold_last_q <= s_axis_tlast;
         end else if (push) begin
            hold_mask_q <= mask_rest;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (push && !fifo_clear_in)
         mem_q[wptr_q] <= push_data;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (fifo_clear_in) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push)
            wptr_q <= wptr_q + 1'b1;
         if (pop)
            rptr_q <= rptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sample_cnt_q <= '0;
         last_seen_q  <= 1'b0;
      end else if (fifo_clear_in) begin
         sample_cnt_q <= '0;
         last_seen_q  <= 1'b0;
      end else begin
         if (push && (sample_cnt_q != '1))
            sample_cnt_q <= sample_cnt_q + 1'b1;
         if (set_last)
            last_seen_q <= 1'b1;
      end
   end

   assign s_axis_tready    = tready_c;
   assign fifo_empty_out   = empty;
   assign fifo_data_out    = empty ? '0 : mem_q[rptr_q];
   assign fifo_count_out   = count_q;
   assign sample_count_out = sample_cnt_q;
   assign last_seen_out    = last_seen_q;
   assign dbg_state        = state_q;

endmodule
